debug_cmd_dispatch: RTL and testbench
=====================================

DEBUG_CMD_DISPATCH -- requirements
Module: debug_cmd_dispatch

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of debug targets, 1..16.
REQ-002 SHALL have parameter SR_W, default 38: width of the debug shift-register image.
REQ-003 SHALL have parameter IR_W, default 2: instruction-register width.
REQ-004 SHALL have parameter TIMEOUT, default 255: pending-abort limit in cycles, >=1; used only under the configuration macro.
REQ-005 SHALL have port clk, input, 1: the single clock for all logic.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-007 SHALL have port sr, input, SR_W: shift-register image, stable while vs_e1dr is high.
REQ-008 SHALL have port ir_in, input, IR_W: instruction code, stable while vs_uir is high.
REQ-009 SHALL have port vs_uir, input, 1: asynchronous update-IR level.
REQ-010 SHALL have port vs_e1dr, input, 1: asynchronous exit1-DR level.
REQ-011 SHALL have port tgt_ready, input, NUM_CH: per-target "can accept command" flag.
REQ-012 SHALL have port clr_err, input, 1: clears the sticky error flags.
REQ-013 SHALL have port jdo, output, SR_W: registered command data.
REQ-014 SHALL have port act_valid, output, NUM_CH: one-hot, single-cycle issue pulse.
REQ-015 SHALL have port act_code, output, IR_W: latched instruction code for the issued command.
REQ-016 SHALL have port act_take, output, 1: 1 = take_action, 0 = take_no_action.
REQ-017 SHALL have port busy, output, 1: high while in PEND or ISSUE.
REQ-018 SHALL have port overrun, output, 1: sticky error flag.
REQ-019 SHALL have port timeout_err, output, 1: sticky error flag.

Function
REQ-020 SHALL synchronise vs_uir and vs_e1dr through 2 flops each, then rising-edge-detect them with a third flop.
REQ-021 SHALL latch ir_in into the internal IR register on a uir edge.
REQ-022 SHALL decode sr[SR_W-1 -: CH_W] as the channel number, with CH_W = max(1, clog2(NUM_CH)).
REQ-023 SHALL decode sr[SR_W-1-CH_W] as the take bit.
REQ-024 SHALL implement FSM IDLE/PEND/ISSUE.
  - IDLE, on e1dr edge: capture sr into jdo and the IR register into act_code; go to ISSUE if tgt_ready[ch], else to PEND.
  - PEND: go to ISSUE on the first cycle tgt_ready[ch] is high.
  - ISSUE: assert act_valid[ch] for exactly one cycle, then return to IDLE.
REQ-025 SHALL, when vs_e1dr rises at input cycle N with the target ready, assert act_valid during cycle N+3.
REQ-026 SHALL treat a channel number >= NUM_CH as invalid: capture jdo, issue no pulse, set overrun, stay in IDLE.
REQ-027 SHALL, on an e1dr edge arriving in PEND or ISSUE, drop the new command, leave jdo unchanged and set overrun.
REQ-028 SHALL, when a uir edge and an e1dr edge occur in the same cycle, capture act_code from the pre-update IR register.
REQ-029 SHALL hold jdo and act_code stable from capture until the next accepted e1dr edge.
REQ-030 SHALL, when clr_err and a new error event occur in the same cycle, let the error win and keep the flag set.

Reset
REQ-031 SHALL, on reset assertion, immediately force: FSM to IDLE; jdo, act_code and the IR register to 0; act_valid to 0; act_take, busy, overrun and timeout_err to 0; sync flops to 0.
REQ-032 SHALL, when reset asserts during PEND, discard the pending command without issuing a pulse.
REQ-033 SHALL, if vs_e1dr is high at reset release, issue no command until vs_e1dr falls and rises again.

Configuration
REQ-034 SHALL, with DBG_DISPATCH_TIMEOUT_EN defined, count cycles in PEND.
  - When the count reaches TIMEOUT: abort to IDLE without a pulse and set timeout_err.
  - The counter clears on leaving PEND.
REQ-035 SHALL, without DBG_DISPATCH_TIMEOUT_EN, never time out PEND, tie timeout_err to 0, and accept and ignore the TIMEOUT parameter.

Structure
REQ-036 SHALL place the FSM state enum and a clog2-based CH_W helper function in the shared package debug_pkg.
REQ-037 SHALL implement the synchroniser plus edge detector as the sub-module debug_sync_edge, instantiated twice.

Verification
REQ-038 SHALL cover ready target: NUM_CH=2, sr={ch=1, take=1, data=0x15}, ir_in=2 via uir, tgt_ready=2'b11, pulse vs_e1dr -> act_valid=2'b10 for one cycle at N+3, act_take=1, act_code=2, jdo=sr.
REQ-039 SHALL cover stalled target: tgt_ready[0]=0 with a command to ch 0 -> busy=1 with no pulse; raise tgt_ready[0] at cycle M -> act_valid=2'b01 at M+1.
REQ-040 SHALL cover overrun: a second vs_e1dr edge while in PEND -> overrun=1, jdo unchanged; clr_err -> overrun=0 next cycle.
REQ-041 SHALL cover invalid channel: NUM_CH=3, channel field = 3 -> no act_valid, overrun=1.
REQ-042 SHALL cover timeout (macro on, TIMEOUT=4): target never ready -> timeout_err=1 after 4 PEND cycles, then busy=0.
REQ-043 SHALL cover mid-PEND reset: assert reset during PEND -> all outputs 0 immediately, and no act_valid after release.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and helpers for the debug command dispatcher.
package debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ISSUE = 2'd2
  } dispatch_state_e;

  // Channel-field width; a single target still gets a 1-bit field.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/debug_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for one asynchronous level.
// Edges are masked until the synchronised level has been seen low after reset.
module debug_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise_c
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic       r_armed;
  logic [1:0] r_fill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_fill <= {r_fill[0], 1'b1};
      // r_s2 only reflects the real input once the pipeline has refilled
      if (r_fill[1] && !r_s2) r_armed <= 1'b1;
    end
  end

  assign o_rise_c = r_s2 & ~r_s3 & r_armed;

endmodule

// File: rtl/debug_cmd_dispatch.sv
// Dispatches debug shift-register commands to one of NUM_CH targets.
// Optional PEND abort timer enabled by defining DBG_DISPATCH_TIMEOUT_EN.
module debug_cmd_dispatch
  import debug_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned SR_W    = 38,
  parameter int unsigned IR_W    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SR_W-1:0]   sr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic              vs_uir,
  input  logic              vs_e1dr,
  input  logic [NUM_CH-1:0] tgt_ready,
  input  logic              clr_err,
  output logic [SR_W-1:0]   jdo,
  output logic [NUM_CH-1:0] act_valid,
  output logic [IR_W-1:0]   act_code,
  output logic              act_take,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int unsigned     CH_W     = ch_width(NUM_CH);
  localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic              w_uir_rise;
  logic              w_e1dr_rise;
  dispatch_state_e   r_state;
  dispatch_state_e   w_next;
  logic [IR_W-1:0]   r_ir;
  logic [IR_W-1:0]   r_act_code;
  logic [SR_W-1:0]   r_jdo;
  logic [NUM_CH-1:0] r_act_valid;
  logic              r_act_take;
  logic              r_overrun;
  logic              r_timeout_err;
  logic [CH_W-1:0]   w_ch;
  logic              w_ch_bad;
  logic              w_ready;
  logic [NUM_CH-1:0] w_onehot;
  logic              w_capture;
  logic              w_ovr_set;
  logic              w_to_set;
  logic              w_to_hit;

  debug_sync_edge u_sync_uir (
    .clk      (clk),
    .reset    (reset),
    .i_async  (vs_uir),
    .o_rise_c (w_uir_rise)
  );

  debug_sync_edge u_sync_e1dr (
    .clk      (clk),
    .reset    (reset),
    .i_async  (vs_e1dr),
    .o_rise_c (w_e1dr_rise)
  );

  // In IDLE the incoming image is decoded; afterwards the captured command is.
  assign w_ch     = (r_state == ST_IDLE) ? sr[SR_W-1 -: CH_W] : r_jdo[SR_W-1 -: CH_W];
  assign w_ch_bad = ({1'b0, w_ch} >= NUM_CH_L);
  assign w_ready  = ~w_ch_bad & tgt_ready[w_ch];
  assign w_onehot = NUM_CH'(1) << w_ch;

`ifdef DBG_DISPATCH_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_pend_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_cnt <= '0;
    end else if (r_state == ST_PEND) begin
      r_pend_cnt <= r_pend_cnt + TO_W'(1);
    end else begin
      r_pend_cnt <= '0;
    end
  end

  assign w_to_hit = (r_pend_cnt == TO_W'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_to_hit         = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_ovr_set = 1'b0;
    w_to_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_e1dr_rise) begin
          w_capture = 1'b1;
          if (w_ch_bad)     w_ovr_set = 1'b1;
          else if (w_ready) w_next    = ST_ISSUE;
          else              w_next    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_e1dr_rise) w_ovr_set = 1'b1;
        if (w_ready) begin
          w_next = ST_ISSUE;
        end else if (w_to_hit) begin
          w_next   = ST_IDLE;
          w_to_set = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (w_e1dr_rise) w_ovr_set = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ir          <= '0;
      r_jdo         <= '0;
      r_act_code    <= '0;
      r_act_take    <= 1'b0;
      r_act_valid   <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_uir_rise) r_ir <= ir_in;
      if (w_capture) begin
        r_jdo      <= sr;
        r_act_code <= r_ir;
        r_act_take <= sr[SR_W-1-CH_W];
      end
      r_act_valid <= (w_next == ST_ISSUE) ? w_onehot : '0;
      // A new error in the same cycle as clr_err keeps the flag set
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
      if (w_to_set)     r_timeout_err <= 1'b1;
      else if (clr_err) r_timeout_err <= 1'b0;
    end
  end

  assign jdo         = r_jdo;
  assign act_valid   = r_act_valid;
  assign act_code    = r_act_code;
  assign act_take    = r_act_take;
  assign busy        = (r_state != ST_IDLE);
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_debug_cmd_dispatch.sv
// Directed self-checking bench: a 2-target instance and a 3-target instance (TIMEOUT=4).
module tb_debug_cmd_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ir_in;
  logic        vs_uir;
  logic        clr_err;

  logic [37:0] sr2, jdo2;
  logic        e1dr2, take2, busy2, ovr2, toe2;
  logic [1:0]  rdy2, av2, code2;

  logic [37:0] sr3, jdo3;
  logic        e1dr3, take3, busy3, ovr3, toe3;
  logic [2:0]  rdy3, av3;
  logic [1:0]  code3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  debug_cmd_dispatch #(.NUM_CH(2), .SR_W(38), .IR_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .sr(sr2), .ir_in(ir_in), .vs_uir(vs_uir),
    .vs_e1dr(e1dr2), .tgt_ready(rdy2), .clr_err(clr_err), .jdo(jdo2),
    .act_valid(av2), .act_code(code2), .act_take(take2), .busy(busy2),
    .overrun(ovr2), .timeout_err(toe2)
  );

  debug_cmd_dispatch #(.NUM_CH(3), .SR_W(38), .IR_W(2), .TIMEOUT(4)) u_dut3 (
    .clk(clk), .reset(reset), .sr(sr3), .ir_in(ir_in), .vs_uir(vs_uir),
    .vs_e1dr(e1dr3), .tgt_ready(rdy3), .clr_err(clr_err), .jdo(jdo3),
    .act_valid(av3), .act_code(code3), .act_take(take3), .busy(busy3),
    .overrun(ovr3), .timeout_err(toe3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [1:0] av_seen;

  initial begin
    reset = 1'b1; ir_in = '0; vs_uir = 1'b0; clr_err = 1'b0;
    sr2 = '0; e1dr2 = 1'b0; rdy2 = '0;
    sr3 = '0; e1dr3 = 1'b0; rdy3 = '0;
    tick(3);
    chk("rst_jdo", 64'(jdo2), 64'd0);
    chk("rst_av", 64'(av2), 64'd0);
    chk("rst_busy", 64'(busy2), 64'd0);
    chk("rst_flags", 64'({ovr2, toe2, take2, code2}), 64'd0);
    reset = 1'b0;
    tick(5);

    // Load IR = 2
    ir_in = 2'd2; vs_uir = 1'b1;
    tick(4);
    vs_uir = 1'b0;
    tick(2);

    // Ready target: ch1, take1, data 0x15; pulse at N+3
    sr2 = {1'b1, 1'b1, 36'h15}; rdy2 = 2'b11; e1dr2 = 1'b1;
    tick(2);
    chk("rdy_av_n2", 64'(av2), 64'd0);
    tick(1);
    chk("rdy_av_n3", 64'(av2), 64'h2);
    chk("rdy_take", 64'(take2), 64'd1);
    chk("rdy_code", 64'(code2), 64'd2);
    chk("rdy_jdo", 64'(jdo2), {26'd0, 1'b1, 1'b1, 36'h15});
    tick(1);
    chk("rdy_av_n4", 64'(av2), 64'd0);
    chk("rdy_busy_n4", 64'(busy2), 64'd0);
    e1dr2 = 1'b0;
    tick(3);

    // Stalled target 0
    sr2 = {1'b0, 1'b0, 36'hABC}; rdy2 = 2'b10; e1dr2 = 1'b1;
    tick(3);
    chk("stall_busy", 64'(busy2), 64'd1);
    chk("stall_av", 64'(av2), 64'd0);
    e1dr2 = 1'b0;
    tick(3);
    // Overrun: second edge while pending
    sr2 = {1'b1, 1'b1, 36'h777}; e1dr2 = 1'b1;
    tick(3);
    chk("ovr_flag", 64'(ovr2), 64'd1);
    chk("ovr_jdo", 64'(jdo2), {28'd0, 36'hABC});
    chk("ovr_busy", 64'(busy2), 64'd1);
    e1dr2 = 1'b0;
    tick(2);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("ovr_clr", 64'(ovr2), 64'd0);
    rdy2 = 2'b11;
    tick(1);
    chk("stall_av_m1", 64'(av2), 64'h1);
    chk("stall_take", 64'(take2), 64'd0);
    tick(1);
    chk("stall_done", 64'({av2, busy2}), 64'd0);
    tick(2);

    // Invalid channel 3 on the 3-target instance
    sr3 = {2'd3, 1'b1, 35'h7}; rdy3 = 3'b111; e1dr3 = 1'b1;
    tick(3);
    chk("inv_av", 64'(av3), 64'd0);
    chk("inv_ovr", 64'(ovr3), 64'd1);
    chk("inv_jdo", 64'(jdo3), {26'd0, 2'd3, 1'b1, 35'h7});
    tick(1);
    chk("inv_av2", 64'(av3), 64'd0);
    chk("inv_busy", 64'(busy3), 64'd0);
    e1dr3 = 1'b0;
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(2);

    // Valid channel 2 on the 3-target instance
    sr3 = {2'd2, 1'b0, 35'h1}; e1dr3 = 1'b1;
    tick(3);
    chk("ch2_av", 64'(av3), 64'h4);
    chk("ch2_ovr", 64'(ovr3), 64'd0);
    e1dr3 = 1'b0;
    tick(3);

    // Pending abort timer on the 3-target instance
    sr3 = {2'd0, 1'b1, 35'h2}; rdy3 = 3'b000; e1dr3 = 1'b1;
    tick(3);
    chk("to_busy0", 64'(busy3), 64'd1);
    tick(3);
    chk("to_pre", 64'({toe3, busy3}), 64'b01);
    tick(1);
`ifdef DBG_DISPATCH_TIMEOUT_EN
    chk("to_fire", 64'({toe3, busy3}), 64'b10);
`else
    chk("to_none", 64'({toe3, busy3}), 64'b01);
`endif
    chk("to_av", 64'(av3), 64'd0);
    rdy3 = 3'b001;
    tick(2);
    chk("to_idle", 64'(busy3), 64'd0);
    e1dr3 = 1'b0;
    tick(3);

    // uir and e1dr edges together: act_code uses the old IR
    sr2 = {1'b1, 1'b0, 36'h5A}; rdy2 = 2'b11;
    ir_in = 2'd1; vs_uir = 1'b1; e1dr2 = 1'b1;
    tick(3);
    chk("same_code_old", 64'(code2), 64'd2);
    chk("same_av", 64'(av2), 64'h2);
    vs_uir = 1'b0; e1dr2 = 1'b0;
    tick(3);
    e1dr2 = 1'b1;
    tick(3);
    chk("same_code_new", 64'(code2), 64'd1);
    e1dr2 = 1'b0;
    tick(3);

    // Reset while pending; e1dr held high across release
    sr2 = {1'b0, 1'b1, 36'h3}; rdy2 = 2'b00; e1dr2 = 1'b1;
    tick(3);
    chk("mid_busy", 64'(busy2), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy2), 64'd0);
    chk("mid_rst_jdo", 64'(jdo2), 64'd0);
    chk("mid_rst_misc", 64'({av2, code2, take2, ovr2, toe2}), 64'd0);
    rdy2 = 2'b11;
    tick(2);
    reset = 1'b0;
    av_seen = '0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      av_seen = av_seen | av2;
    end
    chk("mid_no_pulse", 64'(av_seen), 64'd0);
    e1dr2 = 1'b0;
    tick(4);
    e1dr2 = 1'b1;
    tick(3);
    chk("rearm_av", 64'(av2), 64'h1);
    chk("rearm_code", 64'(code2), 64'd0);
    e1dr2 = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
